pe_conv_sequencer: RTL and testbench

Generates the per-cycle control strobes that drive one 3x3 convolution pass through a single PE. It replaces hand-sequenced stimulus:
- filter load,
- image line streaming,
- MAC warm-up,
- output-valid masking of invalid border columns and rows.

It sits between the layer controller, which issues `start` and the image geometry, and the PE control inputs and the image/filter memory read ports.

---
 rtl/pe_conv_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_pe_conv_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_conv_sequencer.sv
// Control-strobe sequencer for one 3x3 convolution pass through a single PE.
// stall is sampled on the clock edge, so its zeroed strobes appear on the following cycle.
module pe_conv_sequencer #(
   parameter int unsigned DIM_W   = 10,
   parameter int unsigned MAC_LAT = 2,
   parameter int unsigned K_TAPS  = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DIM_W-1:0] im_w,
   input  logic [DIM_W-1:0] im_h,
   input  logic             last_bank,
   input  logic             stall,
   output logic             busy,
   output logic             done,
   output logic             cfg_err,
   output logic             line_buffer_reset,
   output logic             shifting_filter,
   output logic             flt_rd,
   output logic             shifting_line,
   output logic             img_rd,
   output logic             img_pad,
   output logic             mac_enable,
   output logic             adder_enable,
   output logic             final_filter_bank,
   output logic             out_valid
);

   localparam int unsigned TW = 2 * DIM_W + 2;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [TW-1:0]    t_q, t_d;
   logic [TW-1:0]    wh_q, wh_d;
   logic [TW-1:0]    mac_lo_q, mac_lo_d;
   logic [TW-1:0]    t0_q, t0_d;
   logic [TW-1:0]    t_end;
   logic [TW-1:0]    line_end;
   logic [TW-1:0]    adder_end;
   logic [DIM_W-1:0] w_q, w_d;
   logic [DIM_W-1:0] h_q, h_d;
   logic [DIM_W-1:0] col_q, col_d;
   logic [DIM_W-1:0] row_q, row_d;

   logic emit;
   logic ffb_d, cfg_err_d, lbr_d, done_d, busy_d;
   logic sf_d, sl_d, ird_d, pad_d, mac_d, add_d, ov_d;

   assign t_end = t0_q + wh_q - TW'(1);

   always_comb begin
      state_d   = state_q;
      t_d       = t_q;
      wh_d      = wh_q;
      mac_lo_d  = mac_lo_q;
      t0_d      = t0_q;
      w_d       = w_q;
      h_d       = h_q;
      col_d     = col_q;
      row_d     = row_q;
      ffb_d     = final_filter_bank;
      emit      = 1'b0;
      cfg_err_d = 1'b0;
      lbr_d     = 1'b0;
      done_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if ((im_w < DIM_W'(3)) || (im_h < DIM_W'(3))) begin
                  cfg_err_d = 1'b1;
               end else begin
                  state_d  = StRun;
                  w_d      = im_w;
                  h_d      = im_h;
                  wh_d     = TW'(im_w) * TW'(im_h);
                  mac_lo_d = (TW'(im_w) << 1) + TW'(1);
                  t0_d     = mac_lo_d + TW'(MAC_LAT);
                  t_d      = '0;
                  col_d    = '0;
                  row_d    = '0;
                  ffb_d    = last_bank;
                  lbr_d    = 1'b1;
                  emit     = 1'b1;
               end
            end
         end
         StRun: begin
            if (t_q == t_end) begin
               state_d = StDone;
               done_d  = 1'b1;
            end else if (!stall) begin
               t_d  = t_q + TW'(1);
               emit = 1'b1;
               // Output position tracks the step being emitted; it only moves inside the
               // accumulate window, which opens at t0.
               if (t_q >= t0_q) begin
                  if (col_q == w_q - DIM_W'(1)) begin
                     col_d = '0;
                     row_d = row_q + DIM_W'(1);
                  end else begin
                     col_d = col_q + DIM_W'(1);
                  end
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      busy_d = (state_d != StIdle);
   end

   // Strobes are decoded from the step about to be presented, so they can be registered.
   always_comb begin
      line_end  = mac_lo_d + wh_d - TW'(1);
      adder_end = t0_d + wh_d - TW'(1);
      sf_d      = emit && (t_d <= TW'(K_TAPS - 1));
      sl_d      = emit && (t_d <= line_end);
      ird_d     = emit && (t_d < wh_d);
      pad_d     = emit && (t_d >= wh_d) && (t_d <= line_end);
      mac_d     = emit && (t_d >= mac_lo_d) && (t_d <= line_end);
      add_d     = emit && (t_d >= t0_d) && (t_d <= adder_end);
      ov_d      = add_d && (col_d < w_d - DIM_W'(2)) && (row_d < h_d - DIM_W'(2));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         t_q      <= '0;
         wh_q     <= '0;
         mac_lo_q <= '0;
         t0_q     <= '0;
         w_q      <= '0;
         h_q      <= '0;
         col_q    <= '0;
         row_q    <= '0;
      end else begin
         state_q  <= state_d;
         t_q      <= t_d;
         wh_q     <= wh_d;
         mac_lo_q <= mac_lo_d;
         t0_q     <= t0_d;
         w_q      <= w_d;
         h_q      <= h_d;
         col_q    <= col_d;
         row_q    <= row_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy              <= 1'b0;
         done              <= 1'b0;
         cfg_err           <= 1'b0;
         line_buffer_reset <= 1'b0;
         shifting_filter   <= 1'b0;
         flt_rd            <= 1'b0;
         shifting_line     <= 1'b0;
         img_rd            <= 1'b0;
         img_pad           <= 1'b0;
         mac_enable        <= 1'b0;
         adder_enable      <= 1'b0;
         final_filter_bank <= 1'b0;
         out_valid         <= 1'b0;
      end else begin
         busy              <= busy_d;
         done              <= done_d;
         cfg_err           <= cfg_err_d;
         line_buffer_reset <= lbr_d;
         shifting_filter   <= sf_d;
         flt_rd            <= sf_d;
         shifting_line     <= sl_d;
         img_rd            <= ird_d;
         img_pad           <= pad_d;
         mac_enable        <= mac_d;
         adder_enable      <= add_d;
         final_filter_bank <= ffb_d;
         out_valid         <= ov_d;
      end
   end

endmodule

// File: tb/tb_pe_conv_sequencer.sv
// Scoreboard bench for pe_conv_sequencer: a window-arithmetic model predicts every output
// cycle; a separate monitor pops and compares, and checks valid-output counts per pass.
module tb_pe_conv_sequencer;

   localparam int DIM_W   = 10;
   localparam int MAC_LAT = 2;
   localparam int K_TAPS  = 9;

   localparam int B_BUSY = 12, B_DONE = 11, B_CFG = 10, B_LBR = 9, B_SF = 8, B_FRD = 7;
   localparam int B_SL = 6, B_IRD = 5, B_PAD = 4, B_MAC = 3, B_ADD = 2, B_FFB = 1, B_OV = 0;

   typedef logic [12:0] vec_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic [DIM_W-1:0] im_w = '0;
   logic [DIM_W-1:0] im_h = '0;
   logic             last_bank = 1'b0;
   logic             stall = 1'b0;
   logic             busy, done, cfg_err, line_buffer_reset, shifting_filter, flt_rd;
   logic             shifting_line, img_rd, img_pad, mac_enable, adder_enable;
   logic             final_filter_bank, out_valid;

   pe_conv_sequencer #(
      .DIM_W   (DIM_W),
      .MAC_LAT (MAC_LAT),
      .K_TAPS  (K_TAPS)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .im_w              (im_w),
      .im_h              (im_h),
      .last_bank         (last_bank),
      .stall             (stall),
      .busy              (busy),
      .done              (done),
      .cfg_err           (cfg_err),
      .line_buffer_reset (line_buffer_reset),
      .shifting_filter   (shifting_filter),
      .flt_rd            (flt_rd),
      .shifting_line     (shifting_line),
      .img_rd            (img_rd),
      .img_pad           (img_pad),
      .mac_enable        (mac_enable),
      .adder_enable      (adder_enable),
      .final_filter_bank (final_filter_bank),
      .out_valid         (out_valid)
   );

   always #5 clk = ~clk;

   vec_t exp_q[$];
   int   cnt_q[$];
   int   checks = 0;
   int   errors = 0;
   int   valid_cnt = 0;

   // Reference model state: 0 idle, 1 running, 2 done cycle
   int m_mode = 0;
   int m_t = 0;
   int m_w = 0;
   int m_h = 0;
   bit m_ffb = 1'b0;

   function automatic vec_t dut_vec();
      return {busy, done, cfg_err, line_buffer_reset, shifting_filter, flt_rd, shifting_line,
              img_rd, img_pad, mac_enable, adder_enable, final_filter_bank, out_valid};
   endfunction

   function automatic int last_step(input int w, input int h);
      return 2 * w + 1 + MAC_LAT + w * h - 1;
   endfunction

   function automatic vec_t strobes(input int t, input int w, input int h);
      vec_t v;
      int   wh, t0, i;
      wh = w * h;
      t0 = 2 * w + 1 + MAC_LAT;
      v = '0;
      v[B_BUSY] = 1'b1;
      v[B_SF]   = (t <= K_TAPS - 1);
      v[B_FRD]  = (t <= K_TAPS - 1);
      v[B_SL]   = (t <= 2 * w + wh);
      v[B_IRD]  = (t < wh);
      v[B_PAD]  = (t >= wh) && (t <= 2 * w + wh);
      v[B_MAC]  = (t >= 2 * w + 1) && (t <= 2 * w + wh);
      v[B_ADD]  = (t >= t0) && (t <= t0 + wh - 1);
      i = t - t0;
      v[B_OV]   = v[B_ADD] && ((i % w) < w - 2) && ((i / w) < h - 2);
      return v;
   endfunction

   task automatic check_vec(input string name, input vec_t got, input vec_t req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s at %0t: got %b required %b (busy,done,cfg_err,lbr,sf,frd,sl,ird,pad,mac,add,ffb,ov)",
                  name, $time, got, req);
      end
   endtask

   task automatic check_int(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         errors++;
         $display("FAIL %s at %0t: got %0d required %0d", name, $time, got, req);
      end
   endtask

   // Monitor: compares whatever the DUT presents against the scoreboard.
   initial begin
      forever begin
         @(posedge clk or negedge rst);
         #1;
         if (!rst) begin
            check_vec("reset_outputs", dut_vec(), '0);
         end else begin
            if (line_buffer_reset) valid_cnt = 0;
            else if (out_valid) valid_cnt++;
            if (exp_q.size() > 0) check_vec("strobes", dut_vec(), exp_q.pop_front());
            if (done && cnt_q.size() > 0) check_int("valid_count", valid_cnt, cnt_q.pop_front());
         end
      end
   end

   // Drive one cycle of inputs and push the outputs the model predicts for the next cycle.
   task automatic cycle(input bit st, input bit sv, input int w, input int h, input bit lb);
      vec_t e;
      @(negedge clk);
      start     = st;
      stall     = sv;
      im_w      = DIM_W'(w);
      im_h      = DIM_W'(h);
      last_bank = lb;
      e = '0;
      case (m_mode)
         0: begin
            if (st) begin
               if (w < 3 || h < 3) begin
                  e[B_CFG] = 1'b1;
               end else begin
                  m_mode = 1;
                  m_t    = 0;
                  m_w    = w;
                  m_h    = h;
                  m_ffb  = lb;
                  e = strobes(0, w, h);
                  e[B_LBR] = 1'b1;
                  cnt_q.push_back((w - 2) * (h - 2));
               end
            end
         end
         1: begin
            if (m_t == last_step(m_w, m_h)) begin
               m_mode = 2;
               e[B_BUSY] = 1'b1;
               e[B_DONE] = 1'b1;
            end else if (!sv) begin
               m_t++;
               e = strobes(m_t, m_w, m_h);
            end else begin
               e[B_BUSY] = 1'b1;
            end
         end
         default: m_mode = 0;
      endcase
      e[B_FFB] = m_ffb;
      exp_q.push_back(e);
   endtask

   // Asserts reset in the middle of the cycle the DUT is presenting.
   task automatic do_reset();
      @(posedge clk);
      #3;
      rst = 1'b0;
      m_mode = 0;
      m_ffb  = 1'b0;
      exp_q.delete();
      cnt_q.delete();
      start = 1'b0;
      stall = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic run_pass(input int w, input int h, input bit lb, input int stall_pct,
                           input int stall_at, input int stall_len, input int abort_t,
                           input bit spam);
      int n, stalled, wv, hv;
      bit st, sv, lbv;
      n = 0;
      stalled = 0;
      cycle(1'b1, 1'b0, w, h, lb);
      while (m_mode != 0 && n < 20000) begin
         if (abort_t >= 0 && m_mode == 1 && m_t == abort_t) begin
            do_reset();
            return;
         end
         st  = spam ? 1'($urandom_range(1)) : 1'b0;
         lbv = spam ? 1'($urandom_range(1)) : lb;
         wv  = spam ? int'($urandom_range(20)) : w;
         hv  = spam ? int'($urandom_range(20)) : h;
         if (stall_at >= 0 && m_mode == 1 && m_t == stall_at && stalled < stall_len) begin
            sv = 1'b1;
            stalled++;
         end else begin
            sv = (int'($urandom_range(99)) < stall_pct);
         end
         cycle(st, sv, wv, hv, lbv);
         n++;
      end
      cycle(1'b0, 1'b0, w, h, lb);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) cycle(1'b0, 1'b0, 0, 0, 1'b0);

      run_pass(4, 4, 1'b1, 0, -1, 0, -1, 1'b0);
      run_pass(5, 3, 1'b0, 0, -1, 0, -1, 1'b0);
      run_pass(4, 4, 1'b0, 0, 5, 3, -1, 1'b0);
      run_pass(2, 10, 1'b1, 0, -1, 0, -1, 1'b0);
      run_pass(3, 3, 1'b1, 0, -1, 0, -1, 1'b0);
      run_pass(8, 8, 1'b1, 0, -1, 0, 10, 1'b0);
      repeat (2) cycle(1'b0, 1'b0, 0, 0, 1'b0);
      run_pass(8, 8, 1'b0, 0, -1, 0, -1, 1'b0);
      run_pass(6, 5, 1'b1, 0, -1, 0, -1, 1'b1);

      for (int k = 0; k < 6; k++) begin
         run_pass(int'($urandom_range(3, 10)), int'($urandom_range(3, 10)),
                  1'($urandom_range(1)), 25, -1, 0, -1, 1'b1);
      end
      run_pass(int'($urandom_range(2)), int'($urandom_range(12)), 1'b1, 0, -1, 0, -1, 1'b0);

      repeat (3) cycle(1'b0, 1'b0, 0, 0, 1'b0);
      @(posedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
